// File: rtl/uart_loader.sv
// uart_loader: serial boot loader. Receives 8N1 UART bytes and writes a framed
// image into memory, then releases the core by raising load_done.
//
// Frame: 0xA5, LEN_HI, LEN_LO, LEN payload bytes, checksum (sum of the payload mod 256).
//
// Ports:
//   clock       sole clock, rising edge
//   reset       synchronous, active-high
//   rx          UART receive line (idle high, LSB first, asynchronous to clock)
//   mem_addr    byte address of the current write
//   mem_data    byte being written
//   mem_req     write request, held until mem_done is sampled
//   mem_write   copy of mem_req
//   mem_done    memory completion strobe (ignored unless a write is pending)
//   load_done   sticky: image loaded and checksum matched
//   load_error  sticky until the next accepted header: last frame failed
//   busy        high from the header byte to the end of the frame
module uart_loader #(
  parameter int CLKS_PER_BIT = 234,
  parameter int MAX_LEN      = 16384
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_req,
  output logic        mem_write,
  input  logic        mem_done,
  output logic        load_done,
  output logic        load_error,
  output logic        busy
);

  localparam int               CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]      MAX_LEN_W = 17'(MAX_LEN);
  localparam logic [7:0]       HEADER    = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE} ld_state_t;

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  rx_state_t        rx_state;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_byte;     // shift register; holds the last byte until the next one
  logic             byte_valid;
  logic             frame_err;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in the block sees the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      // Synchronizers reset to the idle-high level so reset release is never
      // mistaken for a start bit.
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            bit_cnt  <= '0;
          end
        end
        RX_START: begin
          // Re-check half a bit later: a line that is high again was a glitch.
          if (bit_cnt == HALF_LAST) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            rx_byte <= {rx_sync, rx_byte[7:1]};
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else                 bit_idx  <= bit_idx + 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt  <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) byte_valid <= 1'b1;
            else         frame_err  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM (all outputs registered)
  // ---------------------------------------------------------------------------
  ld_state_t   state;
  logic [7:0]  len_hi;
  logic [15:0] length;
  logic [7:0]  checksum;
  logic        abort_write;   // frame failed while a write is in flight

  assign mem_write = mem_req;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      len_hi      <= '0;
      length      <= '0;
      checksum    <= '0;
      abort_write <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      mem_req     <= 1'b0;
      load_done   <= 1'b0;
      load_error  <= 1'b0;
      busy        <= 1'b0;
    end else if (frame_err && state inside {LEN_HI, LEN_LO, DATA, CHECK}) begin
      // A corrupted byte inside a frame kills the frame.
      load_error <= 1'b1;
      busy       <= 1'b0;
      state      <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (byte_valid && rx_byte == HEADER) begin
            state    <= LEN_HI;
            busy     <= 1'b1;
            checksum <= '0;
            mem_addr <= '0;
          end
        end
        LEN_HI: begin
          if (byte_valid) begin
            len_hi <= rx_byte;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (byte_valid) begin
            length <= {len_hi, rx_byte};
            if ({1'b0, len_hi, rx_byte} > MAX_LEN_W) begin
              load_error <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              load_error <= 1'b0;
              state      <= ({len_hi, rx_byte} == 16'd0) ? CHECK : DATA;
            end
          end
        end
        DATA: begin
          // 0xA5 here is ordinary payload.
          if (byte_valid) begin
            mem_data <= rx_byte;
            checksum <= checksum + rx_byte;
            mem_req  <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          // A byte arriving while the holding register is still in use is an
          // overrun; the current write is allowed to finish first.
          if (byte_valid || frame_err) begin
            load_error  <= 1'b1;
            abort_write <= 1'b1;
          end
          if (mem_done) begin
            mem_req  <= 1'b0;
            mem_addr <= mem_addr + 16'd1;
            if (abort_write || byte_valid || frame_err) begin
              abort_write <= 1'b0;
              busy        <= 1'b0;
              state       <= IDLE;
            end else if (mem_addr + 16'd1 == length) begin
              state <= CHECK;
            end else begin
              state <= DATA;
            end
          end
        end
        CHECK: begin
          if (byte_valid) begin
            busy <= 1'b0;
            if (rx_byte == checksum) begin
              load_done  <= 1'b1;
              load_error <= 1'b0;
              state      <= DONE;
            end else begin
              load_error <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        DONE: ;  // terminal until reset
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed frames against a frame-level model of the loader.
`timescale 1ns/1ps
module tb_uart_loader;

  localparam int CPB     = 16;
  localparam int MAX_LEN = 16384;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        mem_done = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_req, mem_write, load_done, load_error, busy;

  always #5 clock = ~clock;

  uart_loader #(.CLKS_PER_BIT(CPB), .MAX_LEN(MAX_LEN)) dut (
    .clock(clock), .reset(reset), .rx(rx),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_req(mem_req),
    .mem_write(mem_write), .mem_done(mem_done),
    .load_done(load_done), .load_error(load_error), .busy(busy)
  );

  typedef struct { logic [15:0] addr; logic [7:0] data; } wr_t;

  wr_t  exp_q[$];
  logic m_done = 1'b0, m_err = 1'b0, m_busy = 1'b0;
  int   total = 0, bad = 0;
  int   stall_cycles = 2;
  logic withhold = 1'b0;
  logic [7:0] fr[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: parses a byte stream and predicts writes and flags.
  function automatic void model_bytes(input logic [7:0] q[$]);
    int i = 0;
    int len;
    logic [7:0] sum;
    while (i < q.size()) begin
      if (m_done) return;
      if (q[i] != 8'hA5) begin i++; continue; end
      m_busy = 1'b1;
      i++;
      if (i + 2 > q.size()) return;
      len = {q[i], q[i+1]};
      i += 2;
      if (len > MAX_LEN) begin m_err = 1'b1; m_busy = 1'b0; continue; end
      m_err = 1'b0;
      sum = 8'h00;
      for (int k = 0; k < len; k++) begin
        if (i >= q.size()) return;
        exp_q.push_back('{addr: 16'(k), data: q[i]});
        sum += q[i];
        i++;
      end
      if (i >= q.size()) return;
      m_busy = 1'b0;
      if (q[i] == sum) begin m_done = 1'b1; m_err = 1'b0; end
      else m_err = 1'b1;
      i++;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = 1'b1;
    repeat (CPB + 4) @(negedge clock);
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic run_frame(input logic [7:0] q[$]);
    model_bytes(q);
    send_q(q);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},    mem_req,    0);
    check({tag, "_mem_write"},  mem_write,  0);
    check({tag, "_mem_addr"},   mem_addr,   0);
    check({tag, "_mem_data"},   mem_data,   0);
    check({tag, "_load_done"},  load_done,  0);
    check({tag, "_load_error"}, load_error, 0);
    check({tag, "_busy"},       busy,       0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clock);
    check_reset_outputs(tag);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic check_status(input string tag);
    repeat (30) @(negedge clock);
    check({tag, "_load_done"},  load_done,    m_done);
    check({tag, "_load_error"}, load_error,   m_err);
    check({tag, "_busy"},       busy,         m_busy);
    check({tag, "_pending"},    exp_q.size(), 0);
  endtask

  // Memory responder: acknowledges a request after stall_cycles, unless withheld.
  initial begin
    int wait_cnt = 0;
    forever begin
      @(negedge clock);
      if (mem_done) begin
        mem_done = 1'b0;
        wait_cnt = 0;
      end else if (mem_req && !withhold) begin
        if (wait_cnt >= stall_cycles) mem_done = 1'b1;
        else wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Compare process: write order/content, request stability, mem_write alias.
  initial begin
    logic        prev_stall = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;
    wr_t         w;
    forever begin
      @(negedge clock);
      #1;
      if (!reset) begin
        check("mem_write_alias", mem_write, mem_req);
        if (prev_stall) begin
          check("stall_req",  mem_req,  1);
          check("stall_addr", mem_addr, prev_addr);
          check("stall_data", mem_data, prev_data);
        end
        if (mem_req && mem_done) begin
          check("write_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("write_addr", mem_addr, w.addr);
            check("write_data", mem_data, w.data);
          end
        end
      end
      prev_stall = !reset && mem_req && !mem_done;
      prev_addr  = mem_addr;
      prev_data  = mem_data;
    end
  end

  initial begin
    // Reset state
    do_reset("reset0");

    // Bad checksum, then a good frame clears the error
    fr = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h04};
    model_bytes(fr);
    check("model_pin_bad_err", m_err, 1);
    check("model_pin_bad_writes", exp_q.size(), 2);
    send_q(fr);
    check_status("bad_sum");

    fr = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    model_bytes(fr);
    check("model_pin_good_writes", exp_q.size(), 3);
    check("model_pin_good_last", exp_q[2].data, 8'h33);
    check("model_pin_good_done", m_done, 1);
    send_q(fr);
    check_status("good");

    // DONE is terminal: a further frame is ignored
    fr = '{8'hA5, 8'h00, 8'h01, 8'h77, 8'h77};
    run_frame(fr);
    check_status("after_done");

    // Oversize then empty frame
    do_reset("reset1");
    fr = '{8'hA5, 8'h40, 8'h01};
    run_frame(fr);
    check_status("oversize");
    check("oversize_err_literal", load_error, 1);

    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    model_bytes(fr);
    check("model_pin_empty_writes", exp_q.size(), 0);
    send_q(fr);
    check_status("empty");

    // Long memory stall; 0xA5 as payload
    do_reset("reset2");
    stall_cycles = 50;
    fr = '{8'hA5, 8'h00, 8'h02, 8'hAB, 8'hA5, 8'h50};
    run_frame(fr);
    check_status("stall");
    stall_cycles = 2;

    // Overrun: second payload byte arrives while the first write is withheld
    do_reset("reset3");
    withhold = 1'b1;
    exp_q.push_back('{addr: 16'h0000, data: 8'h11});
    fr = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22};
    send_q(fr);
    repeat (10) @(negedge clock);
    check("overrun_err_early", load_error, 1);
    check("overrun_busy_early", busy, 1);
    check("overrun_req_held", mem_req, 1);
    withhold = 1'b0;
    m_err = 1'b1; m_busy = 1'b0; m_done = 1'b0;
    check_status("overrun");
    fr = '{8'hA5, 8'h00, 8'h01, 8'h5A, 8'h5A};
    run_frame(fr);
    check_status("after_overrun");

    // Short low glitch between length and checksum must not produce a byte
    do_reset("reset4");
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    model_bytes(fr);
    fr = '{8'hA5, 8'h00, 8'h00};
    send_q(fr);
    rx = 1'b0;
    repeat (CPB / 2 - 3) @(negedge clock);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    send_byte(8'h00);
    check_status("glitch");

    // Reset after the second payload byte of a 4-byte frame
    do_reset("reset5");
    fr = '{8'hA5, 8'h00, 8'h04, 8'h01, 8'h02};
    run_frame(fr);
    check_status("partial");
    do_reset("reset_mid");
    fr = '{8'h03, 8'h04};
    run_frame(fr);
    check_status("leftover");
    fr = '{8'hA5, 8'h00, 8'h02, 8'h09, 8'h08, 8'h11};
    run_frame(fr);
    check_status("reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
